// File: rtl/unisnano_pkg.sv
// rtl/unisnano_pkg.sv - shared UART types and constants; the PARITY state exists only with UNISNANO_UART_PARITY_EN
package unisnano_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

`ifdef UNISNANO_UART_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;
`endif

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/unisnano_sync_fifo.sv
// rtl/unisnano_sync_fifo.sv - single-clock FIFO with push/pop/full/empty/count, shared by the UART sides
module unisnano_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Requests that cannot be honoured are dropped here, so callers may be lax.
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign data_out = mem[rd_ptr];

  // Storage array: no reset, so it can map onto plain registers or RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/unisnano_uart_tx.sv
// rtl/unisnano_uart_tx.sv - buffered 8N1 UART transmitter; UNISNANO_UART_PARITY_EN adds an even parity bit
module unisnano_uart_tx
  import unisnano_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx,
  output logic       busy
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int FAW = $clog2(FIFO_DEPTH);

  uart_tx_state_t            state;
  logic [CW-1:0]             cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic [UART_DATA_BITS-1:0] fifo_data;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [FAW:0]              fifo_count;
  logic                      baud_done;
  logic                      push;
  logic                      pop;
`ifdef UNISNANO_UART_PARITY_EN
  logic                      parity_bit;
`endif

  assign ready_out = !fifo_full;
  assign push      = valid_in && !fifo_full;
  assign baud_done = (cnt == CW'(CLKS_PER_BIT - 1));
  // The head byte leaves the FIFO on the edge a new start bit begins: from IDLE,
  // or straight out of a finished stop bit so back-to-back frames have no gap.
  assign pop       = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_done));

  unisnano_sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .data_in  (data_in),
    .pop      (pop),
    .data_out (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Occupancy can never exceed the configured depth.
  assert property (@(posedge clk) disable iff (rst) fifo_count <= (FAW+1)'(FIFO_DEPTH));

  // Frame sequencer: baud counter, bit index, shift register and registered tx/busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= UART_IDLE_LEVEL;
      busy    <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
`ifdef UNISNANO_UART_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!fifo_empty) begin
            shift <= fifo_data;
`ifdef UNISNANO_UART_PARITY_EN
            parity_bit <= even_parity(fifo_data);
`endif
            tx    <= ~UART_IDLE_LEVEL;
            busy  <= 1'b1;
            state <= START;
          end
        end

        START: begin
          if (baud_done) begin
            cnt   <= '0;
            tx    <= shift[0];
            state <= DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DATA: begin
          if (baud_done) begin
            cnt <= '0;
            if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
              bit_idx <= '0;
`ifdef UNISNANO_UART_PARITY_EN
              tx    <= parity_bit;
              state <= PARITY;
`else
              tx    <= UART_IDLE_LEVEL;
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

`ifdef UNISNANO_UART_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            cnt   <= '0;
            tx    <= UART_IDLE_LEVEL;
            state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif

        STOP: begin
          if (baud_done) begin
            cnt <= '0;
            if (!fifo_empty) begin
              shift <= fifo_data;
`ifdef UNISNANO_UART_PARITY_EN
              parity_bit <= even_parity(fifo_data);
`endif
              tx    <= ~UART_IDLE_LEVEL;
              state <= START;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          state <= IDLE;
          tx    <= UART_IDLE_LEVEL;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unisnano_uart_tx.sv
// tb/tb_unisnano_uart_tx.sv - directed self-checking bench for unisnano_uart_tx
module tb_unisnano_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UNISNANO_UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       tx;
  logic       busy;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  unisnano_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .tx        (tx),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line level for bit position k of the frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UNISNANO_UART_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic push_bytes(input logic [7:0] b [8], input int n);
    for (int i = 0; i < n; i++) begin
      logic acc;
      int   guard;
      guard    = 0;
      data_in  = b[i];
      valid_in = 1'b1;
      do begin
        acc = ready_out;
        tick();
        guard++;
      end while (!acc && guard < 400);
      check_eq($sformatf("push_accepted_%0d", i), acc, 1);
    end
    valid_in = 1'b0;
  endtask

  task automatic expect_frames(input logic [7:0] b [8], input int n, input string tag);
    int waitc;
    waitc = 0;
    while (tx !== 1'b0 && waitc < 12) begin
      tick();
      waitc++;
    end
    check_eq({tag, "_start_seen"}, tx, 0);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < FB * CPB; k++) begin
        check_eq($sformatf("%s_byte%0d_cyc%0d_busy_tx", tag, i, k),
                 {busy, tx}, {1'b1, frame_bit(b[i], k / CPB)});
        tick();
      end
    end
    check_eq({tag, "_busy_end"}, busy, 0);
    check_eq({tag, "_tx_end"}, tx, 1);
  endtask

  initial begin
    logic [7:0] bs [8];
    int         bad_cycles;

    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    for (int i = 0; i < 8; i++) bs[i] = 8'h00;
    tick();
    tick();
    check_eq("rst_tx", tx, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", ready_out, 1);
    rst = 1'b0;
    tick();
    check_eq("idle_tx", tx, 1);

    // Single byte: latency and full frame shape.
    bs[0]    = 8'hA5;
    data_in  = 8'hA5;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    check_eq("lat_tx_after_push_edge", tx, 1);
    check_eq("lat_busy_after_push_edge", busy, 0);
    tick();
    check_eq("lat_tx_low_next_edge", tx, 0);
    expect_frames(bs, 1, "a5");
    repeat (3) tick();

    // Back-to-back frames, no idle gap.
    bs[0] = 8'h00;
    bs[1] = 8'hFF;
    fork
      push_bytes(bs, 2);
      expect_frames(bs, 2, "b2b");
    join
    repeat (3) tick();

    // FIFO full: six bytes with valid held high.
    bs[0] = 8'h11; bs[1] = 8'h22; bs[2] = 8'h33;
    bs[3] = 8'h44; bs[4] = 8'h55; bs[5] = 8'h66;
    fork
      push_bytes(bs, 6);
      expect_frames(bs, 6, "full");
      begin
        repeat (4) tick();
        check_eq("full_ready_before_fifth", ready_out, 1);
        tick();
        check_eq("full_ready_low", ready_out, 0);
      end
    join
    repeat (3) tick();

    // Push on the same edge as a pop with three bytes queued.
    bs[0] = 8'h81; bs[1] = 8'h42; bs[2] = 8'h24; bs[3] = 8'h18; bs[4] = 8'hC3;
    fork
      begin
        push_bytes(bs, 4);
        repeat (37) tick();
        check_eq("pp_ready_before", ready_out, 1);
        data_in  = bs[4];
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        check_eq("pp_ready_after", ready_out, 1);
      end
      expect_frames(bs, 5, "pp");
    join
    repeat (3) tick();

    // Parity-sensitive pair (plain 8N1 frames in the default build).
    bs[0] = 8'h07;
    bs[1] = 8'h03;
    fork
      push_bytes(bs, 2);
      expect_frames(bs, 2, "par");
    join
    repeat (3) tick();

    // Reset in the middle of a frame's data bits with two bytes queued.
    bs[0] = 8'h3C; bs[1] = 8'h5A; bs[2] = 8'h96;
    push_bytes(bs, 3);
    repeat (8) tick();
    check_eq("mid_tx_data_bit1", tx, 0);
    check_eq("mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    check_eq("mid_rst_tx", tx, 1);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_ready", ready_out, 1);
    rst = 1'b0;
    bad_cycles = 0;
    repeat (60) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) bad_cycles++;
    end
    check_eq("post_rst_quiet_cycles", bad_cycles, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
